// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one 5-bit LFSR among NREQ requesters with rejection sampling
// Ports: clk (rising edge), reset (sync, active-low), rnd (LFSR value), req (per-requester request),
//   ack (one-cycle one-hot grant, rnd_out valid), rnd_out (delivered value), err (fallback value given),
//   busy (state != IDLE), stuck (sticky LFSR lock-up flag, cleared only by reset)
module rng_arbiter #(
    parameter int NREQ      = 4,
    parameter int RANGE     = 32,
    parameter int MAX_TRIES = 8,
    parameter int GAP_CYC   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rnd,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [4:0]      rnd_out,
    output logic            err,
    output logic            busy,
    output logic            stuck
);
    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0] NR = (IW+1)'(NREQ);
    typedef enum logic [1:0] {IDLE, DRAW, DONE, GAP} state_t;
    state_t state, state_n;
    logic [IW-1:0] g, g_n, rr, rr_n, pick, g_inc;
    logic [IW:0] idx;
    logic [3:0] tries, tries_n, gap, gap_n;
    logic [4:0] rnd_out_n, prev_rnd;
    logic err_n, found, accept, prev_vld;
    // 6-bit compare so RANGE==32 accepts every value
    assign accept = {1'b0, rnd} < 6'(RANGE);
    assign g_inc = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
    assign ack = (state == DONE) ? NREQ'(1) << g : '0;
    assign busy = state != IDLE;
    // first requester at or above rr, wrapping at NREQ
    always_comb begin
        found = 1'b0;
        pick = '0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr} + (IW+1)'(i);
            if (idx >= NR) idx = idx - NR;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick = idx[IW-1:0];
            end
        end
    end
    always_comb begin
        state_n = state;
        g_n = g;
        rr_n = rr;
        tries_n = tries;
        gap_n = gap;
        rnd_out_n = rnd_out;
        err_n = err;
        case (state)
            IDLE: if (found) begin
                g_n = pick;
                tries_n = '0;
                state_n = DRAW;
            end
            DRAW: if (!req[g]) begin
                rr_n = g_inc;
                gap_n = '0;
                state_n = (GAP_CYC == 0) ? IDLE : GAP;
            end else if (accept) begin
                rnd_out_n = rnd;
                err_n = 1'b0;
                state_n = DONE;
            end else if (tries == 4'(MAX_TRIES - 1)) begin
                rnd_out_n = '0;
                err_n = 1'b1;
                state_n = DONE;
            end else begin
                tries_n = tries + 4'd1;
            end
            DONE: begin
                rr_n = g_inc;
                gap_n = '0;
                state_n = (GAP_CYC == 0) ? IDLE : GAP;
            end
            GAP: if (gap == 4'(GAP_CYC - 1)) state_n = IDLE;
                 else gap_n = gap + 4'd1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            g <= '0;
            rr <= '0;
            tries <= '0;
            gap <= '0;
            rnd_out <= '0;
            err <= 1'b0;
            prev_rnd <= '0;
            prev_vld <= 1'b0;
            stuck <= 1'b0;
        end else begin
            state <= state_n;
            g <= g_n;
            rr <= rr_n;
            tries <= tries_n;
            gap <= gap_n;
            rnd_out <= rnd_out_n;
            err <= err_n;
            prev_rnd <= rnd;
            prev_vld <= 1'b1;
            if (prev_vld && rnd == prev_rnd) stuck <= 1'b1;
        end
    end
endmodule
